// File: rtl/gpu_pkg.sv
// Types and defaults shared between the cores and the program-memory controller,
// so both sides agree on the fetch line width and the controller state encoding.
package gpu_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        READ_WAITING = 2'd1,
        RELAY        = 2'd2
    } ctrl_state_t;

    localparam int DEFAULT_DATA_BITS = 16;
    localparam int DEFAULT_READ_NUM  = 4;

    // Width of a consumer index; kept at least one bit wide for a single consumer.
    function automatic int ptr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/program_mem_controller_rr_picker.sv
// Round-robin picker: first requesting consumer found scanning upward from ptr,
// wrapping modulo N. Purely combinational.
module rr_picker
    import gpu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]           req,
    input  logic [ptr_bits(N)-1:0] ptr,
    output logic                   found,
    output logic [ptr_bits(N)-1:0] idx
);
    localparam int PW = ptr_bits(N);

    logic [PW-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int off = 0; off < N; off++) begin
            cand = PW'((int'(ptr) + off) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/program_mem_controller.sv
// Read-only arbiter between consumer instruction-fetch ports and program-memory
// channels: one line of READ_NUM instructions per transaction, round-robin grant.
module program_mem_controller
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = DEFAULT_DATA_BITS,
    parameter int READ_NUM      = DEFAULT_READ_NUM,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic [NUM_CONSUMERS-1:0]                            consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]             consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                            consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][READ_NUM*DATA_BITS-1:0]    consumer_read_data,
    output logic [NUM_CHANNELS-1:0]                             mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]              mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                             mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][READ_NUM*DATA_BITS-1:0]     mem_read_data
);
    localparam int PW        = ptr_bits(NUM_CONSUMERS);
    localparam int LINE_BITS = READ_NUM * DATA_BITS;

    ctrl_state_t                                   state_q [NUM_CHANNELS];
    ctrl_state_t                                   state_d [NUM_CHANNELS];
    logic [PW-1:0]                                 owner_q [NUM_CHANNELS];
    logic [PW-1:0]                                 owner_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]                       mem_valid_q, mem_valid_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]        mem_addr_q, mem_addr_d;
    logic [NUM_CONSUMERS-1:0]                      ready_q, ready_d;
    logic [NUM_CONSUMERS-1:0]                      serving_q, serving_d;
    logic [NUM_CONSUMERS-1:0][LINE_BITS-1:0]       data_q, data_d;
    logic [PW-1:0]                                 rr_ptr_q, rr_ptr_d;

    logic [NUM_CHANNELS-1:0]                       grant;
    logic [PW-1:0]                                 pick_idx [NUM_CHANNELS];

    // Grant chain: each channel sees the serving mask plus whatever lower channels took this cycle.
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
        logic [NUM_CONSUMERS-1:0] mask_in;
        logic                     found;
        logic                     take;
        logic [PW-1:0]            idx;

        if (gi == 0) begin : g_first
            assign mask_in = serving_q;
        end else begin : g_rest
            assign mask_in = g_ch[gi-1].g_fwd.mask_out;
        end

        rr_picker #(.N(NUM_CONSUMERS)) u_picker (
            .req   (consumer_read_valid & ~mask_in),
            .ptr   (rr_ptr_q),
            .found (found),
            .idx   (idx)
        );

        assign take         = (state_q[gi] == IDLE) && found;
        assign grant[gi]    = take;
        assign pick_idx[gi] = idx;

        if (gi < NUM_CHANNELS - 1) begin : g_fwd
            logic [NUM_CONSUMERS-1:0] mask_out;
            assign mask_out = mask_in | (take ? (NUM_CONSUMERS'(1) << idx) : '0);
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        ready_d     = ready_q;
        serving_d   = serving_q;
        data_d      = data_q;
        rr_ptr_d    = rr_ptr_q;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            case (state_q[ch])
                IDLE: begin
                    if (grant[ch]) begin
                        owner_d[ch]             = pick_idx[ch];
                        serving_d[pick_idx[ch]] = 1'b1;
                        mem_valid_d[ch]         = 1'b1;
                        mem_addr_d[ch]          = consumer_read_address[pick_idx[ch]];
                        state_d[ch]             = READ_WAITING;
                        // Higher channels override, so the pointer follows the last grant.
                        rr_ptr_d = (int'(pick_idx[ch]) == NUM_CONSUMERS - 1)
                                   ? '0 : pick_idx[ch] + PW'(1);
                    end
                end
                READ_WAITING: begin
                    if (mem_read_ready[ch]) begin
                        mem_valid_d[ch]      = 1'b0;
                        ready_d[owner_q[ch]] = 1'b1;
                        data_d[owner_q[ch]]  = mem_read_data[ch];
                        state_d[ch]          = RELAY;
                    end
                end
                RELAY: begin
                    if (!consumer_read_valid[owner_q[ch]]) begin
                        ready_d[owner_q[ch]]   = 1'b0;
                        serving_d[owner_q[ch]] = 1'b0;
                        state_d[ch]            = IDLE;
                    end
                end
                default: state_d[ch] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= IDLE;
                owner_q[ch] <= '0;
            end
            mem_valid_q <= '0;
            mem_addr_q  <= '0;
            ready_q     <= '0;
            serving_q   <= '0;
            data_q      <= '0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            ready_q     <= ready_d;
            serving_q   <= serving_d;
            data_q      <= data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign consumer_read_ready = ready_q;
    assign consumer_read_data  = data_q;
    assign mem_read_valid      = mem_valid_q;
    assign mem_read_address    = mem_addr_q;

endmodule

// File: tb/tb_program_mem_controller.sv
// Bench for program_mem_controller: a one-channel and a two-channel instance, each with a
// 1-cycle memory model, directed scenarios followed by randomized consumer traffic.
module tb_program_mem_controller;

    localparam int NC = 4;
    localparam int A  = 8;
    localparam int LB = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [NC-1:0]          cv1 = '0, cv2 = '0;
    logic [NC-1:0][A-1:0]   ca1 = '0, ca2 = '0;
    logic [NC-1:0]          cr1, cr2;
    logic [NC-1:0][LB-1:0]  cd1, cd2;
    logic [0:0]             mv1, mr1;
    logic [0:0][A-1:0]      ma1;
    logic [0:0][LB-1:0]     md1;
    logic [1:0]             mv2, mr2;
    logic [1:0][A-1:0]      ma2;
    logic [1:0][LB-1:0]     md2;
    logic                   stall1 = 1'b0, stall2 = 1'b0;
    logic [15:0]            mem [256];

    int n_checks = 0;
    int n_fail   = 0;
    int order_q[$];
    int lat_a, lat_b;
    bit mon_en   = 1'b0;
    bit rand_done;

    program_mem_controller #(.NUM_CHANNELS(1)) u_dut1 (
        .clk(clk), .reset(reset_n),
        .consumer_read_valid(cv1), .consumer_read_address(ca1),
        .consumer_read_ready(cr1), .consumer_read_data(cd1),
        .mem_read_valid(mv1), .mem_read_address(ma1),
        .mem_read_ready(mr1), .mem_read_data(md1)
    );

    program_mem_controller #(.NUM_CHANNELS(2)) u_dut2 (
        .clk(clk), .reset(reset_n),
        .consumer_read_valid(cv2), .consumer_read_address(ca2),
        .consumer_read_ready(cr2), .consumer_read_data(cd2),
        .mem_read_valid(mv2), .mem_read_address(ma2),
        .mem_read_ready(mr2), .mem_read_data(md2)
    );

    // Reference line: READ_NUM consecutive words, wrapping inside the memory.
    function automatic logic [LB-1:0] line_of(input logic [A-1:0] a);
        logic [LB-1:0] r;
        for (int i = 0; i < 4; i++) r[i*16 +: 16] = mem[A'(int'(a) + i)];
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mr1 <= '0; md1 <= '0; mr2 <= '0; md2 <= '0;
        end else begin
            mr1[0] <= mv1[0] && !stall1;
            md1[0] <= line_of(ma1[0]);
            for (int ch = 0; ch < 2; ch++) begin
                mr2[ch] <= mv2[ch] && !stall2;
                md2[ch] <= line_of(ma2[ch]);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && mon_en) begin
            check("one_ready_per_channel_dut1", 64'($countones(cr1) <= 1), 64'd1);
            check("ready_bound_dut2", 64'($countones(cr2) <= 2), 64'd1);
        end
    end

    task automatic set_req(input int d, input int c, input logic v, input logic [A-1:0] a);
        if (d == 1) begin cv1[c] = v; ca1[c] = a; end
        else        begin cv2[c] = v; ca2[c] = a; end
    endtask

    function automatic logic get_ready(input int d, input int c);
        return (d == 1) ? cr1[c] : cr2[c];
    endfunction

    function automatic logic [LB-1:0] get_data(input int d, input int c);
        return (d == 1) ? cd1[c] : cd2[c];
    endfunction

    function automatic logic [63:0] order_code();
        logic [63:0] r = '0;
        foreach (order_q[i]) r = (r << 4) | 64'(order_q[i]);
        return r;
    endfunction

    // One consumer transaction: request, wait (bounded) for ready, check line, release.
    task automatic read_line(input int d, input int c, input logic [A-1:0] a, output int lat);
        int cnt = 0;
        set_req(d, c, 1'b1, a);
        while (!get_ready(d, c) && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        lat = cnt;
        check($sformatf("ready_d%0d_c%0d", d, c), 64'(get_ready(d, c)), 64'd1);
        check($sformatf("line_d%0d_c%0d", d, c), get_data(d, c), line_of(a));
        order_q.push_back(c);
        $display("txn dut%0d consumer %0d addr %02h latency %0d data %016h",
                 d, c, a, cnt, get_data(d, c));
        set_req(d, c, 1'b0, a);
        @(negedge clk);
        check($sformatf("ready_drop_d%0d_c%0d", d, c), 64'(get_ready(d, c)), 64'd0);
    endtask

    task automatic do_reset();
        mon_en  = 1'b0;
        reset_n = 1'b0;
        cv1 = '0; cv2 = '0; stall1 = 1'b0; stall2 = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        order_q.delete();
        mon_en = 1'b1;
    endtask

    task automatic rand_consumer(input int d, input int c);
        int lat;
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            read_line(d, c, A'($urandom), lat);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [A-1:0] a;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h70F0; mem[1] = 16'h7123; mem[2] = 16'h7A5C; mem[3] = 16'h7FFE;

        // Reset state
        do_reset();
        check("reset_cready1", 64'(cr1), 64'd0);
        check("reset_mvalid1", 64'(mv1), 64'd0);
        check("reset_maddr1", 64'(ma1), 64'd0);
        check("reset_cdata1_c0", cd1[0], 64'd0);
        check("reset_mvalid2", 64'(mv2), 64'd0);

        // Single read from address 0
        read_line(1, 0, 8'h00, lat_a);
        check("t1_latency", 64'(lat_a), 64'd3);
        check("t1_word0", 64'(cd1[0][15:0]), 64'h70F0);
        check("t1_word3", 64'(cd1[0][63:48]), 64'(mem[3]));
        check("t1_mvalid_low", 64'(mv1), 64'd0);
        check("t1_data_held", cd1[0], line_of(8'h00));

        // Four simultaneous requests on one channel
        do_reset();
        fork
            read_line(1, 0, 8'h00, lat_a);
            read_line(1, 1, 8'h04, lat_b);
            begin int l; read_line(1, 2, 8'h08, l); end
            begin int l; read_line(1, 3, 8'h0C, l); end
        join
        check("t2_order", order_code(), 64'h0123);
        check("t2_first_latency", 64'(lat_a), 64'd3);
        order_q.delete();
        fork
            read_line(1, 1, 8'h10, lat_a);
            read_line(1, 0, 8'h14, lat_b);
        join
        check("t2_ptr_wrapped", order_code(), 64'h01);

        // Fairness: consumer 2 waits while consumer 0 re-requests immediately
        do_reset();
        fork
            begin
                read_line(1, 0, 8'h20, lat_a);
                read_line(1, 0, 8'h24, lat_a);
            end
            begin
                @(negedge clk);
                read_line(1, 2, 8'h30, lat_b);
            end
        join
        check("t3_order", order_code(), 64'h020);

        // Two channels, consumers 1 and 3 together
        do_reset();
        fork
            read_line(2, 1, 8'h40, lat_a);
            read_line(2, 3, 8'h80, lat_b);
            begin
                @(negedge clk);
                check("t4_mvalid", 64'(mv2), 64'h3);
                check("t4_ch0_addr", 64'(ma2[0]), 64'h40);
                check("t4_ch1_addr", 64'(ma2[1]), 64'h80);
            end
        join
        check("t4_latency_c1", 64'(lat_a), 64'd3);
        check("t4_latency_c3", 64'(lat_b), 64'd3);

        // Memory stalled for 10 cycles
        do_reset();
        stall1 = 1'b1;
        fork
            read_line(1, 0, 8'h5A, lat_a);
            begin
                @(negedge clk);
                for (int i = 0; i < 10; i++) begin
                    check("t5_mvalid_held", 64'(mv1), 64'd1);
                    check("t5_maddr_held", 64'(ma1), 64'h5A);
                    check("t5_cready_low", 64'(cr1[0]), 64'd0);
                    @(negedge clk);
                end
                stall1 = 1'b0;
            end
        join
        check("t5_latency", 64'(lat_a), 64'd13);

        // Asynchronous reset while waiting on memory
        do_reset();
        set_req(1, 0, 1'b1, 8'h20);
        @(negedge clk);
        check("t6_in_flight", 64'(mv1), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_mvalid", 64'(mv1), 64'd0);
        check("t6_async_maddr", 64'(ma1), 64'd0);
        check("t6_async_cready", 64'(cr1), 64'd0);
        set_req(1, 0, 1'b0, 8'h20);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        read_line(1, 0, 8'h08, lat_a);
        check("t6_latency_after", 64'(lat_a), 64'd3);

        // Randomized traffic with random memory stalls on both instances
        for (int d = 1; d <= 2; d++) begin
            do_reset();
            rand_done = 1'b0;
            fork
                begin
                    while (!rand_done) begin
                        @(negedge clk);
                        if (d == 1) stall1 = ($urandom_range(0, 3) == 0);
                        else        stall2 = ($urandom_range(0, 3) == 0);
                    end
                end
                begin
                    fork
                        rand_consumer(d, 0);
                        rand_consumer(d, 1);
                        rand_consumer(d, 2);
                        rand_consumer(d, 3);
                    join
                    rand_done = 1'b1;
                end
            join
            stall1 = 1'b0;
            stall2 = 1'b0;
        end
        a = 8'hFE;
        read_line(2, 2, a, lat_a);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
